// File: rtl/gauss_ctrl_pkg.sv
// Shared types and width helpers for the gauss9x9 frame controller.
// Widths are derived from the image geometry at elaboration time.
package gauss_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StGap,
        StFlush,
        StDrain,
        StDone
    } ctrl_state_e;

    localparam int unsigned PixelW = 8;

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned row_w(input int unsigned h, input int unsigned f);
        return clog_w(h + f);
    endfunction

    function automatic int unsigned col_w(input int unsigned w);
        return clog_w(w);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned w, input int unsigned h);
        return clog_w(w * h + 1);
    endfunction

    function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/gauss_frame_ctrl_if.sv
// Pixel source handshake plus the filter-facing pixel/valid lines.
// master = the frame controller, slave = source and filter side.
interface gauss_frame_ctrl_if;

    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       flt_valid;
    logic [7:0] flt_data;
    logic       flt_out_valid;

    modport master (
        input  src_valid,
        input  src_data,
        input  flt_out_valid,
        output src_ready,
        output flt_valid,
        output flt_data
    );

    modport slave (
        output src_valid,
        output src_data,
        output flt_out_valid,
        input  src_ready,
        input  flt_valid,
        input  flt_data
    );

endinterface

// File: rtl/gauss_pixel_pacer.sv
// Registers one-cycle filter pixel pulses and times the idle gap after each.
// gap_done is high in the last gap cycle so the FSM can leave GAP on that edge.
module gauss_pixel_pacer
    import gauss_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [PixelW-1:0] issue_data,
    output logic              flt_valid,
    output logic [PixelW-1:0] flt_data,
    output logic              gap_done
);

    localparam int unsigned    GapW    = clog_w(PIXEL_GAP + 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(PIXEL_GAP);

    logic [GapW-1:0] gap_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            flt_valid <= 1'b0;
            flt_data  <= '0;
            gap_q     <= '0;
        end else begin
            flt_valid <= issue;
            if (issue) begin
                flt_data <= issue_data;
                gap_q    <= GapLoad;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GapW'(1);
            end
        end
    end

    assign gap_done = (gap_q <= GapW'(1));

endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer in front of gauss9x9: paces source pixels, appends flush rows,
// then waits for the filter's output count (or a drain timeout) to close the frame.
module gauss_frame_ctrl
    import gauss_ctrl_pkg::*;
#(
    parameter int unsigned       IMAGE_WIDTH   = 320,
    parameter int unsigned       IMAGE_HEIGHT  = 240,
    parameter int unsigned       PIXEL_GAP     = 8,
    parameter int unsigned       FLUSH_ROWS    = 4,
    parameter logic [PixelW-1:0] FLUSH_VAL     = 8'd0,
    parameter int unsigned       DRAIN_TIMEOUT = 600000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    gauss_frame_ctrl_if.master                         bus,
    output logic                                       busy,
    output logic [row_w(IMAGE_HEIGHT, FLUSH_ROWS)-1:0] in_row,
    output logic [col_w(IMAGE_WIDTH)-1:0]              in_col,
    output logic [cnt_w(IMAGE_WIDTH, IMAGE_HEIGHT)-1:0] out_cnt,
    output logic                                       frame_done,
    output logic                                       timeout
);

    localparam int unsigned RowW         = row_w(IMAGE_HEIGHT, FLUSH_ROWS);
    localparam int unsigned ColW         = col_w(IMAGE_WIDTH);
    localparam int unsigned CntW         = cnt_w(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int unsigned DrainW       = clog_w(DRAIN_TIMEOUT);
    localparam int unsigned FRAME_PIXELS = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);

    localparam logic [ColW-1:0]   ColLast      = ColW'(IMAGE_WIDTH - 1);
    localparam logic [RowW-1:0]   RowImgLast   = RowW'(IMAGE_HEIGHT - 1);
    localparam logic [RowW-1:0]   RowFlushLast = RowW'(IMAGE_HEIGHT + FLUSH_ROWS - 1);
    localparam logic [CntW-1:0]   CntFull      = CntW'(FRAME_PIXELS);
    localparam logic [DrainW-1:0] DrainLast    = DrainW'(DRAIN_TIMEOUT - 1);
    localparam bit                NoGap        = (PIXEL_GAP == 0);
    localparam bit                NoFlush      = (FLUSH_ROWS == 0);

    ctrl_state_e       state_q;
    ctrl_state_e       pend_q;
    logic [DrainW-1:0] drain_q;

    logic              issue;
    logic [PixelW-1:0] issue_data;
    logic              gap_done;
    logic              at_col_last;
    logic              last_img;
    logic              last_flush;
    logic              cnt_en;
    logic              flt_valid_w;
    logic [PixelW-1:0] flt_data_w;

    always_comb begin
        issue      = 1'b0;
        issue_data = FLUSH_VAL;
        if (state_q == StFeed) begin
            issue      = bus.src_valid;
            issue_data = bus.src_data;
        end else if (state_q == StFlush) begin
            issue = 1'b1;
        end
    end

    assign bus.src_ready = (state_q == StFeed);
    assign busy          = (state_q != StIdle);
    assign at_col_last   = (in_col == ColLast);
    assign last_img      = at_col_last && (in_row == RowImgLast);
    assign last_flush    = at_col_last && (in_row == RowFlushLast);
    assign cnt_en        = state_q inside {StFeed, StGap, StFlush, StDrain};
    assign bus.flt_valid = flt_valid_w;
    assign bus.flt_data  = flt_data_w;

    gauss_pixel_pacer #(
        .PIXEL_GAP (PIXEL_GAP)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_data (issue_data),
        .flt_valid  (flt_valid_w),
        .flt_data   (flt_data_w),
        .gap_done   (gap_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            pend_q     <= StIdle;
            drain_q    <= '0;
            in_row     <= '0;
            in_col     <= '0;
            out_cnt    <= '0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state_q != StDrain) drain_q <= '0;

            if (cnt_en && bus.flt_out_valid && (out_cnt != CntFull)) begin
                out_cnt <= out_cnt + CntW'(1);
            end

            // The row index stops at the last flush row instead of wrapping past it.
            if (issue) begin
                if (at_col_last) begin
                    in_col <= '0;
                    if (in_row != RowFlushLast) in_row <= in_row + RowW'(1);
                end else begin
                    in_col <= in_col + ColW'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFeed;
                        in_row  <= '0;
                        in_col  <= '0;
                        out_cnt <= '0;
                        timeout <= 1'b0;
                    end
                end
                StFeed: begin
                    if (issue) begin
                        if (last_img) begin
                            if (NoFlush) begin
                                state_q <= StDrain;
                            end else if (NoGap) begin
                                state_q <= StFlush;
                            end else begin
                                state_q <= StGap;
                                pend_q  <= StFlush;
                            end
                        end else if (!NoGap) begin
                            state_q <= StGap;
                            pend_q  <= StFeed;
                        end
                    end
                end
                StGap: begin
                    if (gap_done) state_q <= pend_q;
                end
                StFlush: begin
                    if (last_flush) begin
                        if (NoGap) begin
                            state_q <= StDrain;
                        end else begin
                            state_q <= StGap;
                            pend_q  <= StDrain;
                        end
                    end else if (!NoGap) begin
                        state_q <= StGap;
                        pend_q  <= StFlush;
                    end
                end
                StDrain: begin
                    if (out_cnt == CntFull) begin
                        state_q    <= StDone;
                        frame_done <= 1'b1;
                    end else if (drain_q == DrainLast) begin
                        state_q    <= StDone;
                        frame_done <= 1'b1;
                        timeout    <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DrainW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Directed bench for gauss_frame_ctrl at an 8x4 image with a one-row-latency filter model;
// a second instance with PIXEL_GAP=0 covers back-to-back issue.
module tb_gauss_frame_ctrl;

    localparam int NPIX   = 32;
    localparam int NISSUE = 40;
    localparam int GAP    = 2;

    typedef struct {
        string name;
        int    stall_at;
        int    stall_len;
        int    limit;
        bit    sat;
        int    exp_issued;
        int    exp_out;
        bit    exp_to;
        int    exp_lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       start0;
    logic       busy, frame_done, timeout;
    logic [2:0] in_row, in_col;
    logic [5:0] out_cnt;
    logic       busy0, frame_done0, timeout0;
    logic [2:0] in_row0, in_col0;
    logic [5:0] out_cnt0;

    gauss_frame_ctrl_if bus ();
    gauss_frame_ctrl_if bus0 ();

    gauss_frame_ctrl #(
        .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXEL_GAP(GAP), .FLUSH_ROWS(1),
        .FLUSH_VAL(8'd0), .DRAIN_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .in_row(in_row),
        .in_col(in_col), .out_cnt(out_cnt), .frame_done(frame_done), .timeout(timeout)
    );

    gauss_frame_ctrl #(
        .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .PIXEL_GAP(0), .FLUSH_ROWS(1),
        .FLUSH_VAL(8'd0), .DRAIN_TIMEOUT(50)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(bus0), .busy(busy0), .in_row(in_row0),
        .in_col(in_col0), .out_cnt(out_cnt0), .frame_done(frame_done0), .timeout(timeout0)
    );

    // Filter model: one gauss_valid per input pixel once a full row has been buffered.
    logic m_clear = 1'b1;
    logic m_pulse = 1'b0;
    logic inj     = 1'b0;
    int   m_in    = 0;
    int   m_out   = 0;
    int   m_limit = 1000;

    always @(posedge clk) begin
        m_pulse <= 1'b0;
        if (m_clear) begin
            m_in  <= 0;
            m_out <= 0;
        end else if (bus.flt_valid) begin
            m_in <= m_in + 1;
            if (m_in >= 8 && m_out < m_limit) begin
                m_pulse <= 1'b1;
                m_out   <= m_out + 1;
            end
        end
    end

    assign bus.flt_out_valid  = m_pulse | inj;
    assign bus0.flt_out_valid = bus0.flt_valid;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int stall_at, input int stall_len,
                                input int limit, input bit sat, input int exp_out,
                                input bit exp_to, input int exp_lat);
        vec_t v;
        v.name       = name;
        v.stall_at   = stall_at;
        v.stall_len  = stall_len;
        v.limit      = limit;
        v.sat        = sat;
        v.exp_issued = NISSUE;
        v.exp_out    = exp_out;
        v.exp_to     = exp_to;
        v.exp_lat    = exp_lat;
        return v;
    endfunction

    task automatic run_frame(input vec_t v);
        int cyc = 0, acc = 0, issued = 0, last_pulse = -1, data_err = 0, irregular = 0;
        int done_cnt = 0, lat = -1, stall_left = 0, stall_idx = 0, quiet_err = 0, post = 0;
        int row_seen = -1, col_seen = -1;
        bit resumed = 1'b0, finished = 1'b0;
        m_limit = v.limit;
        @(negedge clk);
        bus.src_valid = 1'b1;
        bus.src_data  = 8'd0;
        start   = 1'b1;
        m_clear = 1'b1;
        inj     = 1'b0;
        while (cyc < 400 && !finished) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            m_clear = 1'b0;
            inj     = 1'b0;
            if (bus.flt_valid) begin
                if (bus.flt_data !== ((issued < NPIX) ? 8'(issued) : 8'd0)) data_err++;
                if (last_pulse >= 0 && (cyc - last_pulse) != GAP + 1) irregular++;
                last_pulse = cyc;
                issued++;
            end
            if (stall_idx >= 1 && !resumed && bus.flt_valid) quiet_err++;
            if (stall_idx == 10 && !resumed) begin
                row_seen = int'(in_row);
                col_seen = int'(in_col);
            end
            if (frame_done) begin
                done_cnt++;
                if (lat < 0) lat = cyc - last_pulse;
            end
            if (done_cnt > 0) begin
                post++;
                if (post == 1 && v.sat) start = 1'b1;
                if (post == 2) check({v.name, ".idle_after_done"}, 32'(busy), 32'd0);
                if (post == 3) finished = 1'b1;
            end
            if (v.stall_len > 0 && acc == v.stall_at && stall_idx == 0 && stall_left == 0)
                stall_left = v.stall_len;
            if (stall_left > 0) begin
                bus.src_valid = 1'b0;
                stall_left--;
                stall_idx++;
            end else begin
                bus.src_valid = (acc < NPIX);
                if (stall_idx > 0) resumed = 1'b1;
            end
            bus.src_data = 8'(acc);
            if (bus.src_valid && bus.src_ready) begin
                acc++;
                if (v.sat && (acc == 5 || acc == 20)) start = 1'b1;
            end
            if (v.sat && (cyc == 3 || cyc == 8 || cyc == 13 || cyc == 18)) inj = 1'b1;
        end
        bus.src_valid = 1'b0;
        check({v.name, ".finished_in_budget"}, 32'(finished), 32'd1);
        check({v.name, ".issued"}, 32'(issued), 32'(v.exp_issued));
        check({v.name, ".data_errors"}, 32'(data_err), 32'd0);
        check({v.name, ".irregular_spacing"}, 32'(irregular), (v.stall_len > 0) ? 32'd1 : 32'd0);
        check({v.name, ".done_pulses"}, 32'(done_cnt), 32'd1);
        check({v.name, ".done_latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, ".out_cnt"}, 32'(out_cnt), 32'(v.exp_out));
        check({v.name, ".timeout"}, 32'(timeout), 32'(v.exp_to));
        if (v.stall_len > 0) begin
            check({v.name, ".quiet_in_stall"}, 32'(quiet_err), 32'd0);
            check({v.name, ".row_in_stall"}, 32'(row_seen), 32'd1);
            check({v.name, ".col_in_stall"}, 32'(col_seen), 32'd3);
        end
    endtask

    vec_t vecs[4];

    initial begin
        int cnt, run, maxrun, done0;
        bit hit;
        vecs[0] = mk("basic",   0,  0, 1000, 1'b0, 32, 1'b0, 3);
        vecs[1] = mk("stall",   11, 20, 1000, 1'b0, 32, 1'b0, 3);
        vecs[2] = mk("timeout", 0,  0, 30,   1'b0, 30, 1'b1, 52);
        vecs[3] = mk("sat",     0,  0, 1000, 1'b1, 32, 1'b0, 3);

        rst            = 1'b0;
        start          = 1'b0;
        start0         = 1'b0;
        bus.src_valid  = 1'b0;
        bus.src_data   = 8'd0;
        bus0.src_valid = 1'b1;
        bus0.src_data  = 8'd7;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_row", 32'(in_row), 32'd0);
        check("rst.in_col", 32'(in_col), 32'd0);
        check("rst.out_cnt", 32'(out_cnt), 32'd0);
        check("rst.flags", {30'd0, frame_done, timeout}, 32'd0);
        check("rst.flt", {23'd0, bus.flt_valid, bus.flt_data}, 32'd0);
        check("rst.src_ready", 32'(bus.src_ready), 32'd0);
        check("rst.busy0", 32'(busy0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Reset in the middle of the flush rows.
        @(negedge clk);
        bus.src_valid = 1'b1;
        start   = 1'b1;
        m_clear = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_clear = 1'b0;
        cnt = 0;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            bus.src_data = 8'(cnt);
            if (bus.flt_valid) cnt++;
            if (cnt == 35) hit = 1'b1;
        end
        check("midrst.reached_flush", 32'(hit), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.pos", {26'd0, in_row, in_col}, 32'd0);
        check("midrst.out_cnt", 32'(out_cnt), 32'd0);
        check("midrst.flt", {23'd0, bus.flt_valid, bus.flt_data}, 32'd0);
        check("midrst.flags", {30'd0, frame_done, timeout}, 32'd0);
        rst = 1'b1;
        bus.src_valid = 1'b0;
        done0 = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (frame_done || busy) done0++;
        end
        check("midrst.no_done", 32'(done0), 32'd0);
        run_frame(vecs[0]);

        // PIXEL_GAP=0 instance: issue on every cycle.
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt    = 0;
        run    = 0;
        maxrun = 0;
        done0  = 0;
        for (int c = 0; c < 200 && done0 == 0; c++) begin
            @(negedge clk);
            if (bus0.flt_valid) begin
                cnt++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (frame_done0) done0++;
        end
        check("gap0.issued", 32'(cnt), 32'(NISSUE));
        check("gap0.longest_run", 32'(maxrun), 32'(NISSUE));
        check("gap0.done", 32'(done0), 32'd1);
        check("gap0.out_cnt", 32'(out_cnt0), 32'd32);
        check("gap0.timeout", 32'(timeout0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gauss_frame_ctrl.md
Name: gauss_frame_ctrl

Overview:
- Frame sequencer that sits between a pixel source (valid/ready) and the gauss9x9 filter's `gray_valid`/`gray` inputs.
- Paces pixels to the filter at a fixed issue interval and tracks the raster row/column of each issued pixel.
- After the last image pixel, injects flush rows to drain the filter's line buffers.
- Counts `gauss_valid` outputs and signals frame completion, or a timeout if the count is not reached.

Parameters:
- IMAGE_WIDTH, 320, pixels per row; must match the filter instance.
- IMAGE_HEIGHT, 240, rows per frame.
- PIXEL_GAP, 8, idle cycles after each issued pixel; issue interval is PIXEL_GAP+1 cycles; 0 is legal.
- FLUSH_ROWS, 4, rows of flush pixels issued after the image.
- FLUSH_VAL, 8'd0, pixel value used for flush pixels.
- DRAIN_TIMEOUT, 600000, maximum DRAIN cycles before aborting.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- src_valid  in  1  source pixel available.
- src_data  in  8  source pixel.
- src_ready  out  1  controller accepts src_data this cycle.
- flt_valid  out  1  to filter `gray_valid`; one-cycle pulse per issued pixel.
- flt_data  out  8  to filter `gray`.
- flt_out_valid  in  1  from filter `gauss_valid`.
- busy  out  1  high in any state except IDLE.
- in_row  out  clog2(IMAGE_HEIGHT+FLUSH_ROWS)  row of the next pixel to issue.
- in_col  out  clog2(IMAGE_WIDTH)  column of the next pixel to issue.
- out_cnt  out  clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)  filter outputs counted this frame.
- frame_done  out  1  one-cycle pulse on frame completion.
- timeout  out  1  sticky flag; set if DRAIN expires; cleared by the next accepted start.

Behaviour:
- Reset: state=IDLE. All outputs 0, including flt_data, counters and timeout.
- A mid-frame reset aborts the frame unconditionally; no frame_done is produced.
- States: IDLE, FEED, GAP, FLUSH, DRAIN, DONE.
- IDLE:
  - src_ready=0.
  - start=1 → FEED. Clears in_row, in_col, out_cnt and timeout.
- FEED:
  - src_ready=1 combinationally in this state only.
  - Acceptance occurs when src_valid&&src_ready on edge k.
  - On acceptance, flt_valid=1 and flt_data=src_data are registered, so both are visible in the cycle after edge k, for exactly one cycle.
  - in_col increments on acceptance; it wraps to 0 at IMAGE_WIDTH-1, and in_row increments on that wrap.
  - Next state is GAP if PIXEL_GAP>0, else FEED; FLUSH instead if the accepted pixel was the last one (row H-1, col W-1).
- GAP:
  - Counts PIXEL_GAP cycles with src_ready=0, then returns to the pending state (FEED or FLUSH).
  - Back-to-back issue is therefore never faster than PIXEL_GAP+1 cycles.
- FLUSH:
  - Issues FLUSH_ROWS*IMAGE_WIDTH pixels of FLUSH_VAL with the same pacing (flt_valid pulse, then GAP). No source handshake; src_ready=0.
  - in_row continues from IMAGE_HEIGHT upward.
  - After the last flush pixel (and its gap) → DRAIN. If FLUSH_ROWS=0, FEED goes directly to DRAIN.
- DRAIN:
  - Waits until out_cnt==IMAGE_WIDTH*IMAGE_HEIGHT → DONE.
  - After DRAIN_TIMEOUT cycles in DRAIN without reaching the count: timeout=1, → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- out_cnt:
  - Increments on every flt_out_valid in FEED, GAP, FLUSH or DRAIN.
  - Saturates at IMAGE_WIDTH*IMAGE_HEIGHT; extra pulses are ignored.
  - Pulses in IDLE or DONE are ignored.
  - Holds its value after DONE until the next accepted start.
- start asserted while busy is ignored, including in the DONE cycle.
- A source stall (src_valid=0 in FEED) holds state indefinitely; no flush or timeout runs while stalled.
- flt_out_valid coinciding with the transition into DONE is still counted, up to saturation.

Decomposition:
- Package gauss_ctrl_pkg holds:
  - state enum (IDLE, FEED, GAP, FLUSH, DRAIN, DONE);
  - width constants/functions derived from IMAGE_WIDTH, IMAGE_HEIGHT and FLUSH_ROWS;
  - FRAME_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT.
- One sub-module, gauss_pixel_pacer:
  - inputs: issue request and PIXEL_GAP;
  - outputs: the registered flt_valid/flt_data pulse and the gap-done indication.
- The FSM and counters remain in gauss_frame_ctrl.

Test Plan:
- Config for all scenarios: IMAGE_WIDTH=8, IMAGE_HEIGHT=4, PIXEL_GAP=2, FLUSH_ROWS=1, DRAIN_TIMEOUT=50, with a gauss9x9 model.
- Basic frame: start, source always valid with values 0..31 → 32 image + 8 flush flt_valid pulses, each spaced exactly 3 cycles. Flush pixels carry flt_data=0. out_cnt=32, then one frame_done pulse, timeout=0.
- Source stall: src_valid low for 20 cycles after pixel 10 → no flt_valid during the stall; in_row=1, in_col=3 held; the frame still completes with 40 issued pixels.
- Timeout: filter model suppressed so only 30 flt_out_valid pulses arrive → DRAIN lasts 50 cycles, then timeout=1, frame_done pulse, out_cnt=30.
- Start while busy plus saturation: start pulses mid-FEED have no effect; 36 flt_out_valid pulses → out_cnt saturates at 32.
- Reset mid-FLUSH: rst=0 for 1 cycle → the next cycle shows IDLE with all outputs 0; no frame_done; a new start runs a clean frame.
- PIXEL_GAP=0 variant: continuous src_valid → flt_valid high on consecutive cycles for 40 cycles.
